// File: rtl/id_hazard_unit.sv
// rtl/id_hazard_unit.sv - ID-stage forwarding, dependence stall and serialisation drain control
module id_hazard_unit #(
    parameter int NUM_SRC = 2,
    parameter int BUBBLES = 4,
    parameter int DATAW   = 32
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     valid_IN,
    input  logic [5*NUM_SRC-1:0]     src_reg_IN,
    input  logic [NUM_SRC-1:0]       src_used_IN,
    input  logic [DATAW*NUM_SRC-1:0] src_raw_IN,
    input  logic                     is_branch_IN,
    input  logic                     serialize_IN,
    input  logic                     notify_IN,
    input  logic [4:0]               exe_wreg_IN,
    input  logic                     exe_regwrite_IN,
    input  logic                     exe_memread_IN,
    input  logic [4:0]               mem_wreg_IN,
    input  logic                     mem_regwrite_IN,
    input  logic                     mem_memread_IN,
    input  logic [DATAW-1:0]         mem_data_IN,
    input  logic [4:0]               wb_wreg_IN,
    input  logic                     wb_regwrite_IN,
    input  logic [DATAW-1:0]         wb_data_IN,
    output logic [DATAW*NUM_SRC-1:0] src_val_OUT,
    output logic [2*NUM_SRC-1:0]     fwd_sel_OUT,
    output logic                     hazard_OUT,
    output logic                     bubble_OUT,
    output logic                     issue_serial_OUT,
    output logic                     WANT_FREEZE,
    output logic                     SYS,
    output logic [15:0]              stall_count_OUT,
    output logic [15:0]              serial_count_OUT
);
    localparam int CW = $clog2(BUBBLES + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(BUBBLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, DRAIN, NOTIFY, RELEASE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          notify_q, notify_d;
    logic          sys_q, sys_d;
    logic [15:0]   stall_count_q, stall_count_d;
    logic [15:0]   serial_count_q, serial_count_d;
    logic          load_use, br_exe, br_memload, start;
    logic [4:0]    src_i;

    // Forwarding ignores src_used; only the stall terms care whether a port is read.
    always_comb begin
        src_val_OUT = '0;
        fwd_sel_OUT = '0;
        load_use    = 1'b0;
        br_exe      = 1'b0;
        br_memload  = 1'b0;
        src_i       = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_i = src_reg_IN[5*i +: 5];
            if (src_i != 5'd0 && mem_regwrite_IN && mem_wreg_IN == src_i) begin
                src_val_OUT[DATAW*i +: DATAW] = mem_data_IN;
                fwd_sel_OUT[2*i +: 2]         = 2'b01;
            end else if (src_i != 5'd0 && wb_regwrite_IN && wb_wreg_IN == src_i) begin
                src_val_OUT[DATAW*i +: DATAW] = wb_data_IN;
                fwd_sel_OUT[2*i +: 2]         = 2'b10;
            end else begin
                src_val_OUT[DATAW*i +: DATAW] = src_raw_IN[DATAW*i +: DATAW];
            end
            if (valid_IN && src_used_IN[i] && src_i != 5'd0) begin
                if (src_i == exe_wreg_IN) begin
                    load_use = load_use | exe_memread_IN;
                    br_exe   = br_exe | (is_branch_IN & exe_regwrite_IN);
                end
                if (src_i == mem_wreg_IN)
                    br_memload = br_memload | (is_branch_IN & mem_memread_IN);
            end
        end
    end

    assign hazard_OUT = load_use | br_exe | br_memload;
    assign start      = (state_q == IDLE) && valid_IN && serialize_IN && !hazard_OUT;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        notify_d = notify_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    notify_d = notify_IN;
                    if (BUBBLES == 1) begin
                        state_d = NOTIFY;
                    end else begin
                        state_d = DRAIN;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = NOTIFY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            NOTIFY:  state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // SYS is registered, so it is computed from the state being entered.
        sys_d = (state_d == NOTIFY) && notify_d;
        stall_count_d  = (hazard_OUT && stall_count_q != 16'hFFFF)
                         ? stall_count_q + 16'd1 : stall_count_q;
        serial_count_d = (state_q == NOTIFY && serial_count_q != 16'hFFFF)
                         ? serial_count_q + 16'd1 : serial_count_q;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            notify_q       <= 1'b0;
            sys_q          <= 1'b0;
            stall_count_q  <= '0;
            serial_count_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            notify_q       <= notify_d;
            sys_q          <= sys_d;
            stall_count_q  <= stall_count_d;
            serial_count_q <= serial_count_d;
        end
    end

    assign bubble_OUT       = hazard_OUT | start | (state_q == DRAIN)
                            | ((state_q == RELEASE) & valid_IN & serialize_IN);
    assign WANT_FREEZE      = bubble_OUT & (state_q != NOTIFY);
    assign issue_serial_OUT = (state_q == NOTIFY);
    assign SYS              = sys_q;
    assign stall_count_OUT  = stall_count_q;
    assign serial_count_OUT = serial_count_q;
endmodule

// File: tb/tb_id_hazard_unit.sv
// tb/tb_id_hazard_unit.sv - self-checking bench for id_hazard_unit
module tb_id_hazard_unit;
    localparam int NS  = 2;
    localparam int BUB = 4;
    localparam int DW  = 32;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          valid_IN, is_branch_IN, serialize_IN, notify_IN;
    logic [9:0]    src_reg_IN;
    logic [1:0]    src_used_IN;
    logic [63:0]   src_raw_IN;
    logic [4:0]    exe_wreg_IN, mem_wreg_IN, wb_wreg_IN;
    logic          exe_regwrite_IN, exe_memread_IN;
    logic          mem_regwrite_IN, mem_memread_IN, wb_regwrite_IN;
    logic [31:0]   mem_data_IN, wb_data_IN;
    logic [63:0]   src_val_OUT;
    logic [3:0]    fwd_sel_OUT;
    logic          hazard_OUT, bubble_OUT, issue_serial_OUT, WANT_FREEZE, SYS;
    logic [15:0]   stall_count_OUT, serial_count_OUT;

    int n_chk = 0;
    int n_fail = 0;

    id_hazard_unit #(.NUM_SRC(NS), .BUBBLES(BUB), .DATAW(DW)) dut (
        .CLK(CLK), .RESET(RESET), .valid_IN(valid_IN), .src_reg_IN(src_reg_IN),
        .src_used_IN(src_used_IN), .src_raw_IN(src_raw_IN), .is_branch_IN(is_branch_IN),
        .serialize_IN(serialize_IN), .notify_IN(notify_IN),
        .exe_wreg_IN(exe_wreg_IN), .exe_regwrite_IN(exe_regwrite_IN), .exe_memread_IN(exe_memread_IN),
        .mem_wreg_IN(mem_wreg_IN), .mem_regwrite_IN(mem_regwrite_IN), .mem_memread_IN(mem_memread_IN),
        .mem_data_IN(mem_data_IN), .wb_wreg_IN(wb_wreg_IN), .wb_regwrite_IN(wb_regwrite_IN),
        .wb_data_IN(wb_data_IN), .src_val_OUT(src_val_OUT), .fwd_sel_OUT(fwd_sel_OUT),
        .hazard_OUT(hazard_OUT), .bubble_OUT(bubble_OUT), .issue_serial_OUT(issue_serial_OUT),
        .WANT_FREEZE(WANT_FREEZE), .SYS(SYS), .stall_count_OUT(stall_count_OUT),
        .serial_count_OUT(serial_count_OUT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic adv();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        valid_IN = 0; is_branch_IN = 0; serialize_IN = 0; notify_IN = 0;
        src_reg_IN = '0; src_used_IN = '0;
        src_raw_IN = {32'h2222_0000, 32'h1111_0000};
        exe_wreg_IN = 0; exe_regwrite_IN = 0; exe_memread_IN = 0;
        mem_wreg_IN = 0; mem_regwrite_IN = 0; mem_memread_IN = 0;
        wb_wreg_IN = 0; wb_regwrite_IN = 0;
        mem_data_IN = 32'h0000_AAAA; wb_data_IN = 32'h0000_BBBB;
    endtask

    task automatic ctl(input string tag, input logic b, input logic f, input logic is, input logic sy);
        #1;
        chk({tag, "_bubble"}, bubble_OUT, b);
        chk({tag, "_freeze"}, WANT_FREEZE, f);
        chk({tag, "_issue"}, issue_serial_OUT, is);
        chk({tag, "_sys"}, SYS, sy);
    endtask

    task automatic do_reset();
        RESET = 0;
        idle_inputs();
        adv();
        RESET = 1;
    endtask

    typedef struct {
        logic       valid; logic br; logic [1:0] used;
        logic [4:0] s0; logic [4:0] s1;
        logic [4:0] exe_w; logic exe_rw; logic exe_mr;
        logic [4:0] mem_w; logic mem_rw; logic mem_mr;
        logic [4:0] wb_w; logic wb_rw;
        logic [3:0] exp_sel; logic exp_hz; logic [31:0] exp_v0;
    } vec_t;

    vec_t vecs[15];

    task automatic run_table();
        int exp_stall;
        exp_stall = 0;
        vecs[0]  = '{1,0,2'b11, 5,9, 0,0,0, 5,1,0, 5,1, 4'b0001,0,32'h0000_AAAA};
        vecs[1]  = '{1,0,2'b11, 0,9, 0,0,0, 0,1,0, 0,1, 4'b0000,0,32'h1111_0000};
        vecs[2]  = '{1,0,2'b11, 5,9, 0,0,0, 4,1,0, 5,1, 4'b0010,0,32'h0000_BBBB};
        vecs[3]  = '{1,0,2'b11, 5,9, 5,0,0, 5,0,0, 6,1, 4'b0000,0,32'h1111_0000};
        vecs[4]  = '{1,0,2'b10, 1,7, 7,1,1, 0,0,0, 0,0, 4'b0000,1,32'h1111_0000};
        vecs[5]  = '{1,0,2'b10, 1,7, 7,1,0, 0,0,0, 0,0, 4'b0000,0,32'h1111_0000};
        vecs[6]  = '{1,0,2'b01, 1,7, 7,1,1, 0,0,0, 0,0, 4'b0000,0,32'h1111_0000};
        vecs[7]  = '{1,0,2'b01, 0,7, 0,1,1, 0,0,0, 0,0, 4'b0000,0,32'h1111_0000};
        vecs[8]  = '{0,0,2'b11, 1,7, 7,1,1, 0,0,0, 0,0, 4'b0000,0,32'h1111_0000};
        vecs[9]  = '{1,1,2'b01, 3,9, 3,1,0, 0,0,0, 0,0, 4'b0000,1,32'h1111_0000};
        vecs[10] = '{1,1,2'b01, 3,9, 0,0,0, 3,1,1, 0,0, 4'b0001,1,32'h0000_AAAA};
        vecs[11] = '{1,1,2'b01, 3,9, 0,0,0, 0,0,0, 3,1, 4'b0010,0,32'h0000_BBBB};
        vecs[12] = '{1,0,2'b01, 3,9, 3,1,0, 3,1,0, 0,0, 4'b0001,0,32'h0000_AAAA};
        vecs[13] = '{1,1,2'b01, 3,9, 0,0,0, 3,1,0, 3,1, 4'b0001,0,32'h0000_AAAA};
        vecs[14] = '{1,0,2'b11, 9,9, 0,0,0, 9,1,0, 9,1, 4'b0101,0,32'h0000_AAAA};
        for (int v = 0; v < 15; v++) begin
            idle_inputs();
            valid_IN = vecs[v].valid; is_branch_IN = vecs[v].br; src_used_IN = vecs[v].used;
            src_reg_IN = {vecs[v].s1, vecs[v].s0};
            exe_wreg_IN = vecs[v].exe_w; exe_regwrite_IN = vecs[v].exe_rw; exe_memread_IN = vecs[v].exe_mr;
            mem_wreg_IN = vecs[v].mem_w; mem_regwrite_IN = vecs[v].mem_rw; mem_memread_IN = vecs[v].mem_mr;
            wb_wreg_IN = vecs[v].wb_w; wb_regwrite_IN = vecs[v].wb_rw;
            #1;
            chk($sformatf("vec%0d_sel", v), fwd_sel_OUT, vecs[v].exp_sel);
            chk($sformatf("vec%0d_val0", v), src_val_OUT[31:0], vecs[v].exp_v0);
            chk($sformatf("vec%0d_hazard", v), hazard_OUT, vecs[v].exp_hz);
            chk($sformatf("vec%0d_bubble", v), bubble_OUT, vecs[v].exp_hz);
            chk($sformatf("vec%0d_freeze", v), WANT_FREEZE, vecs[v].exp_hz);
            if (vecs[v].exp_hz) exp_stall++;
            adv();
        end
        idle_inputs();
        #1;
        chk("table_stall_count", stall_count_OUT, 16'(exp_stall));
    endtask

    task automatic run_random(input int ncyc);
        int phase, mstall, mser;
        bit mnot;
        phase = 0; mstall = 0; mser = 0; mnot = 0;
        for (int c = 0; c < ncyc; c++) begin
            logic [31:0] need;
            logic [63:0] ev;
            logic [3:0]  es;
            logic [4:0]  s;
            logic        hz, st, drain, notif, rel, bub;
            valid_IN        = ($urandom_range(0, 9) != 0);
            is_branch_IN    = ($urandom_range(0, 3) == 0);
            serialize_IN    = ($urandom_range(0, 5) == 0);
            notify_IN       = 1'($urandom_range(0, 1));
            src_reg_IN      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            src_used_IN     = 2'($urandom_range(0, 3));
            src_raw_IN      = {$urandom, $urandom};
            exe_wreg_IN     = 5'($urandom_range(0, 7));
            exe_regwrite_IN = 1'($urandom_range(0, 1));
            exe_memread_IN  = ($urandom_range(0, 3) == 0);
            mem_wreg_IN     = 5'($urandom_range(0, 7));
            mem_regwrite_IN = 1'($urandom_range(0, 1));
            mem_memread_IN  = ($urandom_range(0, 3) == 0);
            wb_wreg_IN      = 5'($urandom_range(0, 7));
            wb_regwrite_IN  = 1'($urandom_range(0, 1));
            mem_data_IN     = $urandom;
            wb_data_IN      = $urandom;
            #1;
            need = '0; es = '0; ev = '0;
            for (int i = 0; i < NS; i++) begin
                s = src_reg_IN[5*i +: 5];
                if (valid_IN && src_used_IN[i] && s != 0) need[s] = 1'b1;
                if (s != 0 && mem_regwrite_IN && mem_wreg_IN == s) begin
                    es[2*i +: 2] = 2'b01; ev[32*i +: 32] = mem_data_IN;
                end else if (s != 0 && wb_regwrite_IN && wb_wreg_IN == s) begin
                    es[2*i +: 2] = 2'b10; ev[32*i +: 32] = wb_data_IN;
                end else begin
                    ev[32*i +: 32] = src_raw_IN[32*i +: 32];
                end
            end
            hz = (exe_memread_IN && need[exe_wreg_IN])
               || (is_branch_IN && ((exe_regwrite_IN && need[exe_wreg_IN])
                                    || (mem_memread_IN && need[mem_wreg_IN])));
            st    = (phase == 0) && valid_IN && serialize_IN && !hz;
            drain = (phase >= 1) && (phase <= BUB - 1);
            notif = (phase == BUB);
            rel   = (phase == BUB + 1);
            bub   = hz || st || drain || (rel && valid_IN && serialize_IN);
            chk("rnd_sel", fwd_sel_OUT, es);
            chk("rnd_val", src_val_OUT, ev);
            chk("rnd_hazard", hazard_OUT, hz);
            chk("rnd_bubble", bubble_OUT, bub);
            chk("rnd_freeze", WANT_FREEZE, bub && !notif);
            chk("rnd_issue", issue_serial_OUT, notif);
            chk("rnd_sys", SYS, notif && mnot);
            chk("rnd_stall_count", stall_count_OUT, 16'(mstall));
            chk("rnd_serial_count", serial_count_OUT, 16'(mser));
            if (hz && mstall < 65535) mstall++;
            if (notif && mser < 65535) mser++;
            if (st) begin
                phase = 1; mnot = notify_IN;
            end else if (phase == BUB + 1) begin
                phase = 0;
            end else if (phase > 0) begin
                phase++;
            end
            adv();
        end
    endtask

    initial begin
        idle_inputs();
        @(negedge CLK);
        do_reset();
        ctl("reset", 0, 0, 0, 0);
        chk("reset_stall_count", stall_count_OUT, 0);
        chk("reset_serial_count", serial_count_OUT, 0);

        run_table();

        // syscall: bubbles T..T+3, SYS/issue at T+4, gone at T+5
        idle_inputs(); valid_IN = 1; serialize_IN = 1; notify_IN = 1;
        for (int k = 0; k < BUB; k++) begin ctl("sys_drain", 1, 1, 0, 0); adv(); end
        ctl("sys_notify", 0, 0, 1, 1); adv();
        valid_IN = 0; serialize_IN = 0;
        ctl("sys_release", 0, 0, 0, 0);
        chk("sys_serial_count", serial_count_OUT, 1);
        adv();

        // LL/SC: same timing, no SYS
        valid_IN = 1; serialize_IN = 1; notify_IN = 0;
        for (int k = 0; k < BUB; k++) begin ctl("ll_drain", 1, 1, 0, 0); adv(); end
        ctl("ll_notify", 0, 0, 1, 0); adv();
        valid_IN = 0; serialize_IN = 0;
        ctl("ll_release", 0, 0, 0, 0);
        chk("ll_serial_count", serial_count_OUT, 2);
        adv();

        // back-to-back syscalls: second start lands at T+6
        valid_IN = 1; serialize_IN = 1; notify_IN = 1;
        for (int k = 0; k <= 10; k++) begin
            if (k == 4 || k == 10) ctl($sformatf("b2b_k%0d", k), 0, 0, 1, 1);
            else ctl($sformatf("b2b_k%0d", k), 1, 1, 0, 0);
            adv();
        end
        valid_IN = 0; serialize_IN = 0;
        ctl("b2b_release", 0, 0, 0, 0);
        chk("b2b_serial_count", serial_count_OUT, 4);
        adv();

        // load-use hazard together with serialize: hazard wins for one cycle
        valid_IN = 1; serialize_IN = 1; notify_IN = 0;
        src_reg_IN = {5'd7, 5'd1}; src_used_IN = 2'b10;
        exe_wreg_IN = 7; exe_memread_IN = 1;
        ctl("hs_hazard", 1, 1, 0, 0);
        chk("hs_hazard_out", hazard_OUT, 1);
        adv();
        exe_memread_IN = 0;
        ctl("hs_start", 1, 1, 0, 0);
        chk("hs_stall_count", stall_count_OUT, 4);
        adv();
        for (int k = 2; k < 5; k++) begin ctl("hs_drain", 1, 1, 0, 0); adv(); end
        ctl("hs_notify", 0, 0, 1, 0); adv();
        valid_IN = 0; serialize_IN = 0;
        #1 chk("hs_serial_count", serial_count_OUT, 5);
        adv();

        // reset while draining
        idle_inputs(); valid_IN = 1; serialize_IN = 1; notify_IN = 1;
        ctl("rd_start", 1, 1, 0, 0); adv(); adv();
        RESET = 0; serialize_IN = 0;
        ctl("rd_in_reset", 0, 0, 0, 0);
        chk("rd_stall_count", stall_count_OUT, 0);
        chk("rd_serial_count", serial_count_OUT, 0);
        src_reg_IN = {5'd7, 5'd1}; src_used_IN = 2'b10; exe_wreg_IN = 7; exe_memread_IN = 1;
        ctl("rd_hazard", 1, 1, 0, 0);
        adv();
        idle_inputs(); RESET = 1;
        for (int k = 0; k < 6; k++) begin ctl("rd_after", 0, 0, 0, 0); adv(); end
        #1 chk("rd_after_stall_count", stall_count_OUT, 0);

        // reset while SYS is high clears it asynchronously
        @(negedge CLK);
        valid_IN = 1; serialize_IN = 1; notify_IN = 1;
        for (int k = 0; k < BUB; k++) adv();
        ctl("rn_notify", 0, 0, 1, 1);
        #1 RESET = 0;
        #1;
        chk("rn_sys_async", SYS, 0);
        chk("rn_issue_async", issue_serial_OUT, 0);
        adv();
        idle_inputs(); RESET = 1;

        do_reset();
        run_random(800);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/id_hazard_unit.md
# id_hazard_unit

Parametrised hazard, forwarding and serialisation controller for the ID stage. It resolves the operand values of an arbitrary number of source registers, with EXE/MEM-over-MEM/WB priority. It detects load-use and branch-in-ID dependences that require a freeze. It also sequences a configurable-length pipeline drain around serialising instructions (syscall, LL/SC). It sits between RegFile/Decoder outputs and the ID pipeline register, and drives fetch freeze and the simulator SYS pulse.

## Interface
- NUM_SRC, 2, number of source operand ports (≥1)
- BUBBLES, 4, nops issued before a serialising instruction leaves ID (≥1)
- DATAW, 32, operand width
- CLK  in  1  clock
- RESET  in  1  reset, asynchronous, active-low
- valid_IN  in  1  ID holds a real instruction
- src_reg_IN  in  5*NUM_SRC  source register numbers, port i at [5i+4:5i]
- src_used_IN  in  NUM_SRC  port i is actually read
- src_raw_IN  in  DATAW*NUM_SRC  RegFile values
- is_branch_IN  in  1  branch/jump resolved in ID (needs final operands this cycle)
- serialize_IN  in  1  serialising instruction in ID
- notify_IN  in  1  raise SYS for it (syscall=1, LL/SC=0)
- exe_wreg_IN / exe_regwrite_IN / exe_memread_IN  in  5/1/1  instruction in EXE
- mem_wreg_IN / mem_regwrite_IN / mem_memread_IN  in  5/1/1  instruction in MEM
- mem_data_IN  in  DATAW  EXE/MEM result
- wb_wreg_IN / wb_regwrite_IN  in  5/1  writeback
- wb_data_IN  in  DATAW  MEM/WB result
- src_val_OUT  out  DATAW*NUM_SRC  forwarded operand values (combinational)
- fwd_sel_OUT  out  2*NUM_SRC  per port: 00 RegFile, 01 EXE/MEM, 10 MEM/WB
- hazard_OUT  out  1  dependence stall this cycle (combinational)
- bubble_OUT  out  1  ID must send a nop to EXE this cycle
- issue_serial_OUT  out  1  ID releases the serialising instruction this cycle
- WANT_FREEZE  out  1  fetch/ID hold
- SYS  out  1  registered syscall pulse
- stall_count_OUT  out  16  saturating count of hazard_OUT cycles
- serial_count_OUT  out  16  saturating count of completed serialisations

## Operation
- Forward per port: match requires src≠0. EXE/MEM is selected if mem_regwrite & mem_wreg==src, else MEM/WB if wb_regwrite & wb_wreg==src, else raw. This holds regardless of src_used.
- load_use: valid & ∃i used_i & src_i≠0 & src_i==exe_wreg & exe_memread.
- br_exe: valid & is_branch & ∃i used match exe_wreg with exe_regwrite.
- br_memload: valid & is_branch & ∃i used match mem_wreg with mem_memread.
- hazard_OUT = load_use | br_exe | br_memload.
- FSM states IDLE, DRAIN, NOTIFY, RELEASE, with counter cnt (width clog2(BUBBLES+1)) and latched notify_q.
- start = state∈{IDLE} & valid & serialize & !hazard.
- IDLE: on start, latch notify_q = notify_IN. If BUBBLES==1, go to NOTIFY; else go to DRAIN with cnt = BUBBLES-1.
- DRAIN: if cnt==1, go to NOTIFY; else cnt--. serialize_IN and hazards are ignored for state.
- NOTIFY: always go to RELEASE.
- RELEASE: always go to IDLE. A serialising instruction seen here is frozen but not started.
- bubble_OUT = hazard | start | DRAIN | (RELEASE & valid & serialize).
- WANT_FREEZE = bubble_OUT & state≠NOTIFY.
- issue_serial_OUT = (state==NOTIFY).
- SYS is 1 exactly during NOTIFY iff notify_q, and 0 otherwise.
- serial_count increments on NOTIFY→RELEASE. stall_count increments when hazard_OUT=1. Both saturate at 0xFFFF.

## Timing
- Forwarding and hazard are same-cycle combinational. The only registered outputs are SYS and the counters.
- Serialisation entered at cycle T (start) gives bubbles in T..T+BUBBLES-1, issue_serial and SYS at T+BUBBLES, RELEASE at T+BUBBLES+1, and the earliest next start at T+BUBBLES+2.
- Reset (including mid-DRAIN/NOTIFY) immediately forces IDLE, cnt=0, notify_q=0, SYS=0 and counters=0.
- When hazard and serialize occur together, the hazard wins and start is delayed until the hazard clears.

## Test plan
- src0=5: mem_wreg=5 with regwrite and mem_data=0xAAAA; wb_wreg=5 with wb_data=0xBBBB → src_val0=0xAAAA, sel=01. Register 0 always gives raw/00.
- exe_wreg=7, exe_memread=1, used src1=7 → hazard, bubble, WANT_FREEZE=1 for 1 cycle. With exe_memread=0 and not a branch → no stall, stall_count unchanged.
- is_branch with src0=3 and exe_wreg=3 with regwrite → stall. Then mem_wreg=3 with memread → stall. Then wb only → sel=10, no stall.
- BUBBLES=4, syscall (notify=1) held at T → bubbles T..T+3; SYS=1, issue_serial=1 and WANT_FREEZE=0 at T+4; SYS=0 at T+5; serial_count=1.
- LL (notify=0) → same sequence with SYS never 1. Back-to-back syscalls → second starts at T+6.
- RESET low during DRAIN → immediate IDLE, SYS=0, counters 0, WANT_FREEZE follows hazards only.
